// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine with req/ready bus, lane steering and watchdog
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_word_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic [31:0] err_addr
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] wd_cnt;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic             is_load, is_store, mem_instr, aligned, accept, reject, timeout;
    logic [31:0]      wdata_n, shifted, load_ext;
    logic [3:0]       strb_n;
    // Decode the EX/MEM entry: classify, check alignment, and raise stall while an access is in flight
    always_comb begin
        is_load   = in_valid && (opcode == OP_LOAD);
        is_store  = in_valid && (opcode == OP_STORE);
        mem_instr = is_load || is_store;
        aligned   = is_store
                  ? ((funct3 == 3'b000) ||
                     ((funct3 == 3'b001) && !mem_addr[0]) ||
                     ((funct3 == 3'b010) && (mem_addr[1:0] == 2'b00)))
                  : ((funct3 == 3'b000) || (funct3 == 3'b100) ||
                     (((funct3 == 3'b001) || (funct3 == 3'b101)) && !mem_addr[0]) ||
                     ((funct3 == 3'b010) && (mem_addr[1:0] == 2'b00)));
        accept    = (state == IDLE) && mem_instr && aligned;
        reject    = (state == IDLE) && mem_instr && !aligned;
        stall     = accept || (state == REQ);
    end
    // Store lane replication and byte enables; loads drive no strobes
    always_comb begin
        wdata_n = (funct3[1:0] == 2'b00) ? {4{store_data[7:0]}}
                : (funct3[1:0] == 2'b01) ? {2{store_data[15:0]}}
                : store_data;
        strb_n  = !is_store              ? 4'b0000
                : (funct3 == 3'b000)     ? 4'b0001 << mem_addr[1:0]
                : (funct3 == 3'b001)     ? 4'b0011 << mem_addr[1:0]
                : 4'b1111;
    end
    // Load extraction: shift the addressed byte/half down to bit 0, then extend
    always_comb begin
        shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
        load_ext = (f3_q == 3'b000) ? {{24{shifted[7]}}, shifted[7:0]}
                 : (f3_q == 3'b100) ? {24'b0, shifted[7:0]}
                 : (f3_q == 3'b001) ? {{16{shifted[15]}}, shifted[15:0]}
                 : (f3_q == 3'b101) ? {16'b0, shifted[15:0]}
                 : shifted;
        timeout  = (wd_cnt == CNT_W'(TIMEOUT - 1));
    end
    // Access FSM with registered bus, result and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            f3_q          <= '0;
            addr_q        <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_word_addr <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            load_valid    <= 1'b0;
            load_data     <= '0;
            misaligned    <= 1'b0;
            bus_error     <= 1'b0;
            err_addr      <= '0;
        end else begin
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (accept) begin
                        state         <= REQ;
                        mem_req       <= 1'b1;
                        mem_we        <= is_store;
                        mem_word_addr <= {mem_addr[31:2], 2'b00};
                        mem_wdata     <= wdata_n;
                        mem_wstrb     <= strb_n;
                        addr_q        <= mem_addr;
                        f3_q          <= funct3;
                    end
                    if (reject) begin
                        misaligned <= 1'b1;
                        err_addr   <= mem_addr;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state      <= DONE;
                        mem_req    <= 1'b0;
                        load_valid <= !mem_we;
                        load_data  <= mem_we ? '0 : load_ext;
                    end else if (timeout) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        err_addr  <= addr_q;
                        load_data <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a behavioural model
module tb_mem_access_unit;
    localparam int TO = 4;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] store_data = '0;
    logic        stall, mem_req, mem_we, load_valid, misaligned, bus_error;
    logic [31:0] mem_word_addr, mem_wdata, load_data, err_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
        .mem_addr(mem_addr), .store_data(store_data), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_word_addr(mem_word_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .load_valid(load_valid), .load_data(load_data), .misaligned(misaligned),
        .bus_error(bus_error), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_mis(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = (op == LOAD) ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        return !legal || ((a % size_of(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int bits;
        bits = 8 * size_of(f3);
        v = longint'(rd) >> (8 * (a % 4));
        if (bits < 32) begin
            v = v % (longint'(1) << bits);
            if (f3 < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] model_wstrb(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << size_of(f3)) - 1) << (a % 4);
        return st ? m[3:0] : 4'b0000;
    endfunction

    task automatic run_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd, input int waits);
        bit mem, mis, acc, st, to;
        int nreq;
        mem  = (op == LOAD) || (op == STORE);
        mis  = mem && model_mis(op, f3, a);
        acc  = mem && !mis;
        st   = (op == STORE);
        to   = waits >= TO;
        nreq = to ? TO : waits + 1;
        in_valid = 1'b1; opcode = op; funct3 = f3; mem_addr = a; store_data = d;
        mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
        #1;
        chk("stall_accept", stall, acc);
        chk("req_idle", mem_req, 0);
        tick();
        if (!acc) begin
            in_valid = 1'b0; mem_ready = 1'b0;
            #1;
            chk("misaligned", misaligned, mis);
            if (mis) chk("err_addr_mis", err_addr, a);
            chk("req_none", mem_req, 0);
            chk("stall_none", stall, 0);
            chk("lv_none", load_valid, 0);
            tick();
            chk("mis_pulse_end", misaligned, 0);
            return;
        end
        for (int k = 0; k < nreq; k++) begin
            mem_ready = (k == waits);
            mem_rdata = (k == waits) ? rd : $urandom;
            #1;
            chk("req_high", mem_req, 1);
            chk("stall_req", stall, 1);
            chk("we", mem_we, st);
            chk("word_addr", mem_word_addr, {a[31:2], 2'b00});
            chk("wstrb", mem_wstrb, model_wstrb(st, f3, a));
            if (st) chk("wdata", mem_wdata, model_wdata(f3, d));
            chk("lv_early", load_valid, 0);
            chk("berr_early", bus_error, 0);
            tick();
        end
        mem_ready = 1'($urandom % 2); mem_rdata = $urandom;
        #1;
        chk("stall_done", stall, 0);
        chk("req_done", mem_req, 0);
        chk("load_valid", load_valid, !st && !to);
        chk("bus_error", bus_error, to);
        if (!st && !to) chk("load_data", load_data, model_load(f3, a, rd));
        if (to) begin
            chk("load_data_err", load_data, 0);
            chk("err_addr_to", err_addr, a);
        end
        tick();
        in_valid = 1'b0; mem_ready = 1'b0;
        #1;
        chk("no_restart", mem_req, 0);
        chk("lv_pulse_end", load_valid, 0);
        chk("berr_pulse_end", bus_error, 0);
        chk("stall_idle", stall, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_lv", load_valid, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_berr", bus_error, 0);
        chk("rst_eaddr", err_addr, 0);
        chk("rst_waddr", mem_word_addr, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        tick();
        run_access(LOAD,  3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_access(LOAD,  3'b000, 32'h103, 32'h0, 32'h80112233, 0);
        run_access(LOAD,  3'b100, 32'h103, 32'h0, 32'h80112233, 1);
        run_access(LOAD,  3'b001, 32'h102, 32'h0, 32'h80112233, 2);
        run_access(STORE, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0);
        run_access(STORE, 3'b001, 32'h203, 32'h1234, 32'h0, 0);
        run_access(LOAD,  3'b010, 32'h300, 32'h0, 32'h0, 100);
        run_access(LOAD,  3'b010, 32'h304, 32'h0, 32'h5A5A0F0F, TO - 1);
        run_access(ALU,   3'b010, 32'h308, 32'h0, 32'h0, 0);
        in_valid = 1'b1; opcode = LOAD; funct3 = 3'b010; mem_addr = 32'h400; mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rst_seq_req", mem_req, 1);
            tick();
        end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_lv", load_valid, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_req", mem_req, 0);
        chk("post_rst_lv", load_valid, 0);
        chk("post_rst_berr", bus_error, 0);
        run_access(STORE, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0, 1);
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [6:0] op;
            r  = $urandom % 8;
            op = (r < 4) ? LOAD : (r < 7) ? STORE : ALU;
            run_access(op, 3'($urandom), $urandom, $urandom, $urandom, $urandom % 6);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine for the five-stage core. Consumes the effective address and forwarded store data produced by the execute stage for load/store opcodes, runs a req/ready transaction on the data-memory port, and stalls the pipeline until the access completes. Loads return sign- or zero-extended data to the MEM/WB register. Misaligned accesses and bus timeouts are reported as one-cycle error pulses.

## Interface
- TIMEOUT, 16: REQ cycles without `mem_ready` before the access is abandoned (must be ≥1)
- CNT_W, 5: watchdog counter width; must satisfy TIMEOUT < 2^CNT_W
- clk  in  1  clock; all flops rising-edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EX/MEM entry holds a valid instruction
- opcode  in  7  0000011 = load, 0100011 = store; anything else passes through
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only)
- mem_addr  in  32  byte effective address (rs1 + imm)
- store_data  in  32  forwarded rs2 value
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write
- mem_word_addr  out  32  `{mem_addr[31:2], 2'b00}`
- mem_wdata  out  32  store data replicated into lanes
- mem_wstrb  out  4  byte-lane enables; 0 on reads
- mem_rdata  in  32  read word; valid when `mem_ready` = 1
- mem_ready  in  1  transaction complete this cycle
- load_valid  out  1  one-cycle pulse: `load_data` is valid
- load_data  out  32  extended load result
- misaligned  out  1  one-cycle pulse: access rejected, no bus cycle
- bus_error  out  1  one-cycle pulse: watchdog expired
- err_addr  out  32  byte address of the faulting access

## Operation
- States IDLE, REQ and DONE. Reset forces IDLE, and every output register clears to 0.
- Memory instruction: `in_valid` set and opcode is load or store.
- Alignment: H/HU require addr[0]=0. W requires addr[1:0]=00. B/BU are always aligned. Store with funct3 100, 101, 11x, or load with funct3 011, 11x: treat as misaligned.
- IDLE:
  - Aligned memory instruction: latch addr, funct3, and we; build wdata/wstrb; go to REQ; `stall`=1 combinationally in the same cycle.
  - Misaligned memory instruction: next cycle `misaligned`=1 and `err_addr`=mem_addr; stay IDLE; no stall.
  - Anything else: no action.
- Store lanes:
  - SB: wdata = {4{d[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = d, wstrb = 1111.
- REQ:
  - `mem_req`=1, and all bus outputs stay stable for the whole state; `stall`=1.
  - On `mem_ready`: capture `mem_rdata`, go to DONE.
  - Otherwise increment the watchdog. If the count reaches TIMEOUT-1 without `mem_ready`, go to DONE with the error flag set. A `mem_ready` in that same cycle wins over the timeout.
- DONE:
  - `stall`=0. For loads without error: `load_valid`=1.
  - `bus_error`=1 and `err_addr` valid if the watchdog fired; `load_data`=0 on error.
  - Return to IDLE unconditionally. `in_valid` seen in DONE is the completing instruction and must not be restarted.
- Load extraction uses byte = word >> (8·addr[1:0]):
  - LB sign-extends [7:0]; LBU zero-extends [7:0].
  - LH sign-extends [15:0]; LHU zero-extends [15:0].
  - LW passes the word through.
- `mem_ready` outside REQ is ignored. Stores never pulse `load_valid`.
- `rst` in any state returns to IDLE next edge: `mem_req` drops and the watchdog clears.

## Timing
- `stall` is combinational from IDLE decode and from state. Every other output is registered.
- Zero-wait memory (`mem_ready` high in the first REQ cycle): accept in cycle N, `mem_req` in N+1, `load_valid` in N+2. The pipeline stalls for 2 cycles.
- Each wait cycle adds one REQ cycle.
- A timeout asserts `bus_error` exactly TIMEOUT cycles after `mem_req` first rises.
- A back-to-back memory instruction is accepted in the IDLE cycle following DONE. Sustained throughput is therefore 1 access per 3 cycles.
- Error pulses last exactly one cycle.

## Test plan
- LW at 0x100, `mem_ready` immediate, rdata 0xDEADBEEF -> `mem_req` 1 cycle, `load_valid` at N+2, `load_data` 0xDEADBEEF, `stall` high in N and N+1 only.
- LB at 0x103 with rdata 0x80112233, then LBU at the same address -> 0xFFFFFF80, then 0x00000080. LH at 0x102 -> 0xFFFF8011.
- SB at 0x201 with data 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 0010, we=1, word addr 0x200, no `load_valid`.
- SH at 0x203 -> `misaligned` one cycle, `err_addr` 0x203, `mem_req` never rises, `stall` never rises.
- LW with `mem_ready` held low, TIMEOUT=4 -> 4 REQ cycles, then `bus_error` pulse, `load_data`=0, `err_addr` correct. Repeat with `mem_ready` arriving on the 4th cycle -> normal completion, no error.
- `rst` asserted during a 3-wait-cycle load -> `mem_req`=0 next cycle, no `load_valid`. A new SW issued afterwards completes normally.
